// File: rtl/bram_sdp_be_clr_if.sv
// Write/read request bus and read-result bus for bram_sdp_be_clr.
// The master drives requests; the RAM (slave) returns data, valid and init status.
interface bram_sdp_be_clr_if #(
  parameter int DWIDTH = 32,
  parameter int AW     = 10
);
  logic [AW-1:0]       waddr;
  logic [DWIDTH-1:0]   din;
  logic                we;
  logic [DWIDTH/8-1:0] be;
  logic [AW-1:0]       raddr;
  logic                re;
  logic [DWIDTH-1:0]   dout;
  logic                dvalid;
  logic                init_done;

  modport master (
    output waddr, din, we, be, raddr, re,
    input  dout, dvalid, init_done
  );

  modport slave (
    input  waddr, din, we, be, raddr, re,
    output dout, dvalid, init_done
  );
endinterface

// File: rtl/bram_sdp_be_clr.sv
// Simple dual-port RAM with byte enables, read valid pipeline (latency 1+DOREG),
// selectable read-during-write behaviour and optional zero-fill after reset.
module bram_sdp_be_clr #(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 1024,
  parameter int DOREG      = 1,
  parameter int WRMODE     = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bram_sdp_be_clr_if.slave   bus
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              NB      = DWIDTH / 8;
  localparam logic [AW:0]     DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  if ((DWIDTH % 8) != 0 || DWIDTH < 8) begin : g_bad_width
    $error("bram_sdp_be_clr: DWIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_cnt;
  logic              w_init_done;
  logic              w_clr_we;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_rd_inr;
  logic [DWIDTH-1:0] w_rdata;
  logic [DWIDTH-1:0] r_q1;
  logic              r_v1;

  (* syn_ramstyle = "block_ram" *) logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_cnt == LAST) begin
      w_state_nxt = ST_READY;
    end
  end

  always_comb begin
    w_init_done = (r_state == ST_READY);
    w_clr_we    = (r_state == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_clr_we) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign w_wr_ok  = bus.we && w_init_done && ({1'b0, bus.waddr} < DEPTH_W);
  assign w_rd_ok  = bus.re && w_init_done;
  assign w_rd_inr = ({1'b0, bus.raddr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) begin
          r_mem[bus.waddr][8*i +: 8] <= bus.din[8*i +: 8];
        end
      end
    end
  end

  // WRITE_FIRST forwards only the enabled bytes of a colliding write.
  always_comb begin
    w_rdata = '0;
    if (w_rd_inr) begin
      w_rdata = r_mem[bus.raddr];
      if (WRMODE != 0 && w_wr_ok && bus.waddr == bus.raddr) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.be[i]) begin
            w_rdata[8*i +: 8] = bus.din[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_rd_ok;
      if (w_rd_ok) begin
        r_q1 <= w_rdata;
      end
    end
  end

  if (DOREG != 0) begin : g_oreg
    logic [DWIDTH-1:0] r_q2;
    logic              r_v2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_q2 <= r_q1;
        end
      end
    end

    assign bus.dout   = r_q2;
    assign bus.dvalid = r_v2;
  end else begin : g_noreg
    assign bus.dout   = r_q1;
    assign bus.dvalid = r_v1;
  end

  assign bus.init_done = w_init_done;

endmodule

// File: tb/tb_bram_sdp_be_clr.sv
// Directed bench: two RAM instances (16 deep, DOREG=1, READ_FIRST / 12 deep, DOREG=0, WRITE_FIRST).
module tb_bram_sdp_be_clr;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bram_sdp_be_clr_if #(.DWIDTH(32), .AW(4)) a_if ();
  bram_sdp_be_clr_if #(.DWIDTH(32), .AW(4)) b_if ();

  bram_sdp_be_clr #(.DWIDTH(32), .DEPTH(16), .DOREG(1), .WRMODE(0), .CLR_ON_RST(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  bram_sdp_be_clr #(.DWIDTH(32), .DEPTH(12), .DOREG(0), .WRMODE(1), .CLR_ON_RST(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_if.we = 1'b0; a_if.re = 1'b0; a_if.waddr = '0; a_if.raddr = '0; a_if.din = '0; a_if.be = '0;
    b_if.we = 1'b0; b_if.re = 1'b0; b_if.waddr = '0; b_if.raddr = '0; b_if.din = '0; b_if.be = '0;
  endtask

  task automatic wr(input logic [3:0] wa, input logic [31:0] d, input logic [3:0] b);
    a_if.we = 1'b1; a_if.waddr = wa; a_if.din = d; a_if.be = b;
    b_if.we = 1'b1; b_if.waddr = wa; b_if.din = d; b_if.be = b;
    step();
    a_if.we = 1'b0;
    b_if.we = 1'b0;
  endtask

  // One read on both instances, optionally with a write in the same cycle.
  task automatic xfer(input string tag, input logic [3:0] ra, input logic [31:0] ea,
                      input logic [31:0] eb, input logic dw, input logic [3:0] wa,
                      input logic [31:0] d, input logic [3:0] b);
    a_if.re = 1'b1; a_if.raddr = ra; a_if.we = dw; a_if.waddr = wa; a_if.din = d; a_if.be = b;
    b_if.re = 1'b1; b_if.raddr = ra; b_if.we = dw; b_if.waddr = wa; b_if.din = d; b_if.be = b;
    step();
    a_if.re = 1'b0; a_if.we = 1'b0;
    b_if.re = 1'b0; b_if.we = 1'b0;
    chk({tag, "_b_vld1"}, b_if.dvalid, 1);
    chk({tag, "_b_dat1"}, b_if.dout, eb);
    chk({tag, "_a_vld1"}, a_if.dvalid, 0);
    step();
    chk({tag, "_a_vld2"}, a_if.dvalid, 1);
    chk({tag, "_a_dat2"}, a_if.dout, ea);
    chk({tag, "_b_vld2"}, b_if.dvalid, 0);
    chk({tag, "_b_hold"}, b_if.dout, eb);
    step();
    chk({tag, "_a_vld3"}, a_if.dvalid, 0);
    chk({tag, "_a_hold"}, a_if.dout, ea);
  endtask

  // Counts edges from reset release to init_done; requests are dropped per instance once ready.
  task automatic clr_wait(input string tag);
    int na = 0;
    int nb = 0;
    int nv = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (a_if.dvalid || b_if.dvalid) nv++;
      if (a_if.init_done) begin
        a_if.re = 1'b0; a_if.we = 1'b0;
        if (na == 0) na = n;
      end
      if (b_if.init_done) begin
        b_if.re = 1'b0; b_if.we = 1'b0;
        if (nb == 0) nb = n;
      end
      if (na != 0 && nb != 0) break;
    end
    chk({tag, "_done_a"}, 64'(na), 16);
    chk({tag, "_done_b"}, 64'(nb), 12);
    chk({tag, "_no_vld"}, 64'(nv), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_a_dout", a_if.dout, 0);
    chk("rst_a_vld",  a_if.dvalid, 0);
    chk("rst_a_done", a_if.init_done, 0);
    chk("rst_b_dout", b_if.dout, 0);
    chk("rst_b_vld",  b_if.dvalid, 0);
    chk("rst_b_done", b_if.init_done, 0);
    step();
    step();
    rst_n = 1'b1;
    clr_wait("init");

    // Read every entry back-to-back after the clear.
    for (int c = 0; c <= 16; c++) begin
      a_if.re = (c < 16); a_if.raddr = 4'(c);
      b_if.re = (c < 16); b_if.raddr = 4'(c);
      step();
      if (c < 16) begin
        chk($sformatf("clr_b_vld%0d", c), b_if.dvalid, 1);
        chk($sformatf("clr_b_dat%0d", c), b_if.dout, 0);
      end
      if (c >= 1) begin
        chk($sformatf("clr_a_vld%0d", c - 1), a_if.dvalid, 1);
        chk($sformatf("clr_a_dat%0d", c - 1), a_if.dout, 0);
      end
    end
    step();
    chk("clr_a_vld_end", a_if.dvalid, 0);
    chk("clr_b_vld_end", b_if.dvalid, 0);

    wr(4'd5, 32'hDEADBEEF, 4'hF);
    xfer("rd5", 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 4'h0);

    wr(4'd3, 32'h11223344, 4'hF);
    wr(4'd3, 32'hAABBCCDD, 4'b0101);
    xfer("be3", 4'd3, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 4'd0, 32'h0, 4'h0);
    wr(4'd3, 32'h00000000, 4'b0000);
    xfer("be0", 4'd3, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 4'd0, 32'h0, 4'h0);

    wr(4'd7, 32'h01020304, 4'hF);
    xfer("col7",  4'd7, 32'h01020304, 32'h0102FFFF, 1'b1, 4'd7, 32'hFFFFFFFF, 4'b0011);
    xfer("post7", 4'd7, 32'h0102FFFF, 32'h0102FFFF, 1'b0, 4'd0, 32'h0, 4'h0);

    // Address 13 is beyond the 12-deep instance but valid in the 16-deep one.
    wr(4'd1, 32'h00001111, 4'hF);
    wr(4'd13, 32'h0000005A, 4'hF);
    xfer("oor13", 4'd13, 32'h0000005A, 32'h0, 1'b0, 4'd0, 32'h0, 4'h0);
    xfer("ent1",  4'd1,  32'h00001111, 32'h00001111, 1'b0, 4'd0, 32'h0, 4'h0);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) step();
    chk("mid8_pre_a", a_if.init_done, 0);
    rst_n = 1'b0;
    #1;
    chk("mid8_rst_a", a_if.init_done, 0);
    chk("mid8_rst_b", b_if.init_done, 0);
    #1;
    rst_n = 1'b1;
    clr_wait("rst8");

    // Two reads in flight on the registered instance, then an async reset.
    a_if.re = 1'b1; a_if.raddr = 4'd5; a_if.we = 1'b1; a_if.waddr = 4'd5; a_if.din = 32'hFFFFFFFF; a_if.be = 4'hF;
    b_if.re = 1'b1; b_if.raddr = 4'd5; b_if.we = 1'b1; b_if.waddr = 4'd5; b_if.din = 32'hFFFFFFFF; b_if.be = 4'hF;
    step();
    step();
    chk("fly_a_vld", a_if.dvalid, 1);
    chk("fly_b_vld", b_if.dvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("fly_rst_a_vld", a_if.dvalid, 0);
    chk("fly_rst_b_vld", b_if.dvalid, 0);
    chk("fly_rst_a_dout", a_if.dout, 0);
    chk("fly_rst_b_dout", b_if.dout, 0);
    #1;
    rst_n = 1'b1;
    clr_wait("fly");
    xfer("clr5", 4'd5, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
